// File: rtl/conv1_requant_relu_axis.sv
// Requantisation stage behind the conv1 accumulator stream. Per-channel bias,
// fixed-point multiply, rounding shift, ReLU and saturation, with a two-stage skid-free pipeline.
module conv1_requant_relu_axis #(
    parameter int unsigned DATA_W_P   = 8,
    parameter int unsigned ACC_W_P    = 32,
    parameter int unsigned MULT_W     = 16,
    parameter int unsigned SHIFT_W    = 5,
    parameter int unsigned COUT       = 64,
    parameter int unsigned PIX_PER_CH = 3136,
    localparam int unsigned CH_W      = (COUT > 1) ? $clog2(COUT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    output logic                busy,
    output logic                tlast_err,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_addr,
    input  logic [ACC_W_P-1:0]  cfg_bias,
    input  logic [MULT_W-1:0]   cfg_mult,
    input  logic [SHIFT_W-1:0]  cfg_shift,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [ACC_W_P-1:0]  s_axis_tdata,
    input  logic                s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W_P-1:0] m_axis_tdata,
    output logic                m_axis_tlast
);

    localparam int unsigned PIX_W  = (PIX_PER_CH > 1) ? $clog2(PIX_PER_CH) : 1;
    localparam int unsigned SUM_W  = ACC_W_P + 1;
    localparam int unsigned PROD_W = ACC_W_P + MULT_W + 2;

    localparam logic [CH_W-1:0]          CH_LAST  = CH_W'(COUT - 1);
    localparam logic [PIX_W-1:0]         PIX_LAST = PIX_W'(PIX_PER_CH - 1);
    localparam logic signed [PROD_W-1:0] SAT_HI   = PROD_W'((1 << (DATA_W_P - 1)) - 1);

    typedef struct packed {
        logic [ACC_W_P-1:0] bias;
        logic [MULT_W-1:0]  mult;
        logic [SHIFT_W-1:0] shift;
    } coef_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   done_d;

    coef_t coef_q [COUT];

    logic [PIX_W-1:0] pix_cnt;
    logic [CH_W-1:0]  ch_cnt;
    logic             in_full;

    logic                    v1;
    logic signed [SUM_W-1:0] sum1;
    logic [MULT_W-1:0]       mult1;
    logic [SHIFT_W-1:0]      shift1;
    logic                    last1;

    logic rdy1, rdy2;
    logic s_fire, m_fire, start_acc, final_beat;

    logic signed [SUM_W-1:0]  sum_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] half_c;
    logic signed [PROD_W-1:0] rnd_c;
    logic [DATA_W_P-1:0]      sat_c;

    assign busy       = (state_q == ST_RUN);
    assign start_acc  = start && !busy;
    assign rdy2       = !m_axis_tvalid || m_axis_tready;
    assign rdy1       = !v1 || rdy2;
    assign s_axis_tready = busy && rdy1 && !in_full;
    assign s_fire     = s_axis_tvalid && s_axis_tready;
    assign m_fire     = m_axis_tvalid && m_axis_tready;
    assign final_beat = (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);

    // Frame control: busy from accepted start to the handshake of the last output.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (m_fire && m_axis_tlast) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    // Coefficient table; identity after reset, writable only between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < COUT; i++) begin
                coef_q[i] <= '{bias: '0, mult: MULT_W'(1), shift: '0};
            end
        end else if (cfg_we && !busy) begin
            coef_q[cfg_addr] <= '{bias: cfg_bias, mult: cfg_mult, shift: cfg_shift};
        end
    end

    // Beat position within the frame, plus input framing check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt   <= '0;
            ch_cnt    <= '0;
            in_full   <= 1'b0;
            tlast_err <= 1'b0;
        end else if (start_acc) begin
            pix_cnt   <= '0;
            ch_cnt    <= '0;
            in_full   <= 1'b0;
            tlast_err <= 1'b0;
        end else if (s_fire) begin
            if (s_axis_tlast != final_beat) begin
                tlast_err <= 1'b1;
            end
            if (final_beat) begin
                in_full <= 1'b1;
            end
            if (pix_cnt == PIX_LAST) begin
                pix_cnt <= '0;
                ch_cnt  <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + CH_W'(1);
            end else begin
                pix_cnt <= pix_cnt + PIX_W'(1);
            end
        end
    end

    assign sum_c = SUM_W'($signed(s_axis_tdata)) + SUM_W'($signed(coef_q[ch_cnt].bias));

    // Multiply, round half up, then clamp to the non-negative activation range.
    always_comb begin
        prod_c = PROD_W'(sum1) * PROD_W'($signed({1'b0, mult1}));
        half_c = '0;
        if (shift1 != '0) begin
            half_c = PROD_W'(1) << (shift1 - SHIFT_W'(1));
        end
        rnd_c = (prod_c + half_c) >>> shift1;
        sat_c = rnd_c[DATA_W_P-1:0];
        if (rnd_c[PROD_W-1]) begin
            sat_c = '0;
        end else if (rnd_c > SAT_HI) begin
            sat_c = SAT_HI[DATA_W_P-1:0];
        end
    end

    // Two pipeline stages; each loads only when the stage after it can drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            sum1          <= '0;
            mult1         <= '0;
            shift1        <= '0;
            last1         <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (rdy1) begin
                v1 <= s_fire;
                if (s_fire) begin
                    sum1   <= sum_c;
                    mult1  <= coef_q[ch_cnt].mult;
                    shift1 <= coef_q[ch_cnt].shift;
                    last1  <= final_beat;
                end
            end
            if (rdy2) begin
                m_axis_tvalid <= v1;
                if (v1) begin
                    m_axis_tdata <= sat_c;
                    m_axis_tlast <= last1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv1_requant_relu_axis.sv
// Directed bench for conv1_requant_relu_axis with a 2-channel x 4-pixel frame.
module tb_conv1_requant_relu_axis;

    localparam int unsigned NBEAT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        done;
    logic        busy;
    logic        tlast_err;
    logic        cfg_we;
    logic [0:0]  cfg_addr;
    logic [31:0] cfg_bias;
    logic [15:0] cfg_mult;
    logic [4:0]  cfg_shift;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;

    conv1_requant_relu_axis #(
        .DATA_W_P(8), .ACC_W_P(32), .MULT_W(16), .SHIFT_W(5),
        .COUT(2), .PIX_PER_CH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
        .tlast_err(tlast_err), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] acc;
        logic [7:0]  exp;
    } beat_t;

    typedef struct {
        int          base;
        bit          bp;
        int          tlast_pos;
        bit          poke;
        logic [31:0] b0;
        logic [15:0] m0;
        logic [4:0]  s0;
        logic [31:0] b1;
        logic [15:0] m1;
        logic [4:0]  s1;
    } scen_t;

    beat_t vec [24];
    scen_t scen [5];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cfg_write(input logic [0:0] addr, input logic [31:0] b,
                             input logic [15:0] m, input logic [4:0] s);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_bias = b; cfg_mult = m; cfg_shift = s;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_after_start", 64'(busy), 1);
        check("tlast_err_cleared_by_start", 64'(tlast_err), 0);
    endtask

    // Streams one frame (plus extra offered beats) and checks every output handshake.
    task automatic run_frame(input int base, input bit bp, input int tlast_pos, input bit poke);
        int         in_idx = 0;
        int         out_idx = 0;
        int         cyc = 0;
        int         hs_cyc = -1;
        int         val_cyc = -1;
        bit         finished = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_last = 1'b0;
        pulse_start();
        while (!finished && cyc < 300) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = vec[base + ((in_idx < NBEAT) ? in_idx : 0)].acc;
            s_axis_tlast  = (in_idx == tlast_pos);
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = poke && (cyc == 3);
            cfg_we   = poke && (cyc == 3);
            cfg_addr = 1'b1; cfg_bias = -32'sd100; cfg_mult = 16'd1; cfg_shift = 5'd0;
            #1;
            if (prev_stall) begin
                check("hold_valid", 64'(m_axis_tvalid), 1);
                check("hold_data", 64'(m_axis_tdata), 64'(prev_data));
                check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
            end
            if ((in_idx - out_idx) == 2 && !m_axis_tready)
                check("full_pipe_tready", 64'(s_axis_tready), 0);
            if (in_idx >= NBEAT)
                check("extra_beat_blocked", 64'(s_axis_tready), 0);
            if (m_axis_tvalid && val_cyc < 0) val_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("data[%0d]", out_idx), 64'(m_axis_tdata), 64'(vec[base + out_idx].exp));
                check($sformatf("last[%0d]", out_idx), 64'(m_axis_tlast), 64'(out_idx == NBEAT - 1));
                out_idx++;
                if (out_idx == NBEAT) finished = 1'b1;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) begin
                if (hs_cyc < 0) hs_cyc = cyc;
                in_idx++;
            end
            cyc++;
        end
        if (!finished) check("frame_timeout_outputs", 64'(out_idx), 64'(NBEAT));
        if (!bp) check("latency", 64'(val_cyc - hs_cyc), 2);
        @(negedge clk);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        start = 1'b0; cfg_we = 1'b0;
        #1;
        check("done_pulse", 64'(done), 1);
        check("busy_fell", 64'(busy), 0);
        check("drained_valid", 64'(m_axis_tvalid), 0);
        check("idle_tready", 64'(s_axis_tready), 0);
        check("tlast_err_at_done", 64'(tlast_err), 64'(tlast_pos != NBEAT - 1));
        check("beats_accepted", 64'(in_idx), 64'(NBEAT));
        @(negedge clk);
        #1;
        check("done_one_cycle", 64'(done), 0);
        check("tlast_err_sticky", 64'(tlast_err), 64'(tlast_pos != NBEAT - 1));
    endtask

    task automatic run_scen(input int idx, input bit do_cfg);
        if (do_cfg) begin
            cfg_write(1'b0, scen[idx].b0, scen[idx].m0, scen[idx].s0);
            cfg_write(1'b1, scen[idx].b1, scen[idx].m1, scen[idx].s1);
        end
        run_frame(scen[idx].base, scen[idx].bp, scen[idx].tlast_pos, scen[idx].poke);
    endtask

    initial begin
        int accepted;
        // identity frame: saturation and ReLU at the edges
        vec[0]  = '{acc: -32'sd5,  exp: 8'd0};
        vec[1]  = '{acc: 32'sd0,   exp: 8'd0};
        vec[2]  = '{acc: 32'sd100, exp: 8'd100};
        vec[3]  = '{acc: 32'sd200, exp: 8'd127};
        vec[4]  = '{acc: 32'sd127, exp: 8'd127};
        vec[5]  = '{acc: 32'sd128, exp: 8'd127};
        vec[6]  = '{acc: -32'sd1,  exp: 8'd0};
        vec[7]  = '{acc: 32'sd1,   exp: 8'd1};
        // ch0 rounding (bias 1, x3, >>2), ch1 identity
        vec[8]  = '{acc: 32'sd5,   exp: 8'd5};
        vec[9]  = '{acc: 32'sd6,   exp: 8'd5};
        vec[10] = '{acc: 32'sd9,   exp: 8'd8};
        vec[11] = '{acc: -32'sd2,  exp: 8'd0};
        vec[12] = '{acc: 32'sd3,   exp: 8'd3};
        vec[13] = '{acc: -32'sd7,  exp: 8'd0};
        vec[14] = '{acc: 32'sd300, exp: 8'd127};
        vec[15] = '{acc: 32'sd42,  exp: 8'd42};
        // channel switch: ch1 bias -100
        for (int i = 16; i < 20; i++) vec[i] = '{acc: 32'sd150, exp: 8'd127};
        for (int i = 20; i < 24; i++) vec[i] = '{acc: 32'sd150, exp: 8'd50};

        scen[0] = '{base: 0,  bp: 1'b0, tlast_pos: 7, poke: 1'b0,
                    b0: 32'sd0, m0: 16'd1, s0: 5'd0, b1: 32'sd0, m1: 16'd1, s1: 5'd0};
        scen[1] = '{base: 8,  bp: 1'b0, tlast_pos: 7, poke: 1'b0,
                    b0: 32'sd1, m0: 16'd3, s0: 5'd2, b1: 32'sd0, m1: 16'd1, s1: 5'd0};
        scen[2] = '{base: 16, bp: 1'b0, tlast_pos: 7, poke: 1'b0,
                    b0: 32'sd0, m0: 16'd1, s0: 5'd0, b1: -32'sd100, m1: 16'd1, s1: 5'd0};
        scen[3] = '{base: 0,  bp: 1'b1, tlast_pos: 7, poke: 1'b0,
                    b0: 32'sd0, m0: 16'd1, s0: 5'd0, b1: 32'sd0, m1: 16'd1, s1: 5'd0};
        scen[4] = '{base: 0,  bp: 1'b0, tlast_pos: 2, poke: 1'b1,
                    b0: 32'sd0, m0: 16'd1, s0: 5'd0, b1: 32'sd0, m1: 16'd1, s1: 5'd0};

        rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_bias = '0; cfg_mult = '0; cfg_shift = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_m_valid", 64'(m_axis_tvalid), 0);
        check("rst_m_data", 64'(m_axis_tdata), 0);
        check("rst_m_last", 64'(m_axis_tlast), 0);
        check("rst_s_tready", 64'(s_axis_tready), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_tlast_err", 64'(tlast_err), 0);

        for (int s = 0; s < 5; s++) run_scen(s, 1'b1);
        // table untouched by the write attempted mid-frame; tlast_err cleared by start
        run_scen(0, 1'b0);

        // reset in the middle of a frame
        cfg_write(1'b0, 32'sd0, 16'd1, 5'd0);
        cfg_write(1'b1, -32'sd100, 16'd1, 5'd0);
        pulse_start();
        accepted = 0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 50 && accepted < 3; c++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'sd150; s_axis_tlast = 1'b0;
            #1;
            if (s_axis_tready) accepted++;
        end
        check("pre_reset_accepted", 64'(accepted), 3);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        #1;
        check("pre_reset_valid", 64'(m_axis_tvalid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(m_axis_tvalid), 0);
        check("midrst_s_tready", 64'(s_axis_tready), 0);
        check("midrst_busy", 64'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // identity table after reset, then the rewritten channel-switch frame
        run_scen(0, 1'b0);
        run_scen(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
